dsi_pkt_builder: RTL and testbench

DSI_PKT_BUILDER -- requirements
Module: dsi_pkt_builder

---
 rtl/dsi_pkg.sv | 15 +
 rtl/dsi_crc16_2b.sv | 19 +
 rtl/dsi_pkt_builder.sv | 117 +++++++++++
 tb/tb_dsi_pkt_builder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// dsi_pkg: FSM states, data-type constants, CRC constants and header ECC for the DSI packet builder
package dsi_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, CRC, TAIL} state_t;
    localparam logic [5:0]  DT_DCS_SHORT_WR = 6'h05;
    localparam logic [5:0]  DT_DCS_LONG_WR  = 6'h39;
    localparam logic [15:0] CRC_SEED        = 16'hFFFF;
    // x^16+x^12+x^5+1 bit-reversed, because bytes are shifted in LSB first
    localparam logic [15:0] CRC_POLY        = 16'h8408;

    // Each mask selects the header bits that feed one parity bit P0..P5
    function automatic logic [7:0] dsi_ecc(input logic [23:0] h);
        return {2'b00, ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
                ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
    endfunction
endpackage

// File: rtl/dsi_crc16_2b.sv
// dsi_crc16_2b: combinational CRC-16 step over one or two payload bytes
// Ports: crc_in current CRC, d byte pair ([7:0] first), nbytes 1 or 2, crc_out updated CRC
module dsi_crc16_2b (
    input  logic [15:0] crc_in,
    input  logic [15:0] d,
    input  logic [1:0]  nbytes,
    output logic [15:0] crc_out
);
    import dsi_pkg::*;

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 16; i++) begin
            if (i < 8 || nbytes == 2'd2) begin
                crc_out = {1'b0, crc_out[15:1]} ^ ((crc_out[0] ^ d[i]) ? CRC_POLY : 16'h0000);
            end
        end
    end
endmodule

// File: rtl/dsi_pkt_builder.sv
// dsi_pkt_builder: builds DSI short/long packets onto two byte lanes with ECC and payload CRC
// Ports: CLKOP/reset_n clock and async low reset; cmd_* packet request; pl_* payload beats;
//        byte_D0/D1, vld_D0/D1, pkt_last lane outputs; busy; err_underrun sticky flag, err_clr
module dsi_pkt_builder (
    input  logic        CLKOP,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_long,
    input  logic [1:0]  cmd_vc,
    input  logic [5:0]  cmd_dt,
    input  logic [15:0] cmd_wc,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [15:0] pl_data,
    output logic [7:0]  byte_D0,
    output logic [7:0]  byte_D1,
    output logic        vld_D0,
    output logic        vld_D1,
    output logic        pkt_last,
    output logic        busy,
    output logic        err_underrun,
    input  logic        err_clr
);
    import dsi_pkg::*;

    state_t      state, state_nx;
    logic        long_q;
    logic [23:0] hdr;
    logic [15:0] remain, crc, crc_nx, pay;
    logic [1:0]  nb;

    // Missing payload is replaced by zeros so the packet keeps its length
    assign pay = pl_valid ? pl_data : 16'h0000;
    assign nb  = (remain == 16'd1) ? 2'd1 : 2'd2;

    dsi_crc16_2b u_crc (
        .crc_in (crc),
        .d      (pay),
        .nbytes (nb),
        .crc_out(crc_nx)
    );

    always_ff @(posedge CLKOP or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            long_q       <= 1'b0;
            hdr          <= '0;
            remain       <= '0;
            crc          <= CRC_SEED;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_nx;
            err_underrun <= (state == PAY && !pl_valid) || (err_underrun && !err_clr);
            if (cmd_valid && cmd_ready) begin
                long_q <= cmd_long;
                hdr    <= {cmd_wc, cmd_vc, cmd_dt};
                remain <= cmd_long ? cmd_wc : 16'h0000;
                crc    <= CRC_SEED;
            end else if (state == PAY) begin
                remain <= remain - {14'd0, nb};
                crc    <= crc_nx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        pl_ready  = 1'b0;
        byte_D0   = 8'h00;
        byte_D1   = 8'h00;
        vld_D0    = 1'b0;
        vld_D1    = 1'b0;
        pkt_last  = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                state_nx  = cmd_valid ? HDR0 : IDLE;
            end
            HDR0: begin
                {byte_D1, byte_D0} = hdr[15:0];
                {vld_D1, vld_D0}   = 2'b11;
                state_nx           = HDR1;
            end
            HDR1: begin
                byte_D0          = hdr[23:16];
                byte_D1          = dsi_ecc(hdr);
                {vld_D1, vld_D0} = 2'b11;
                pkt_last         = !long_q;
                state_nx         = !long_q ? IDLE : (remain == 16'd0 ? CRC : PAY);
            end
            PAY: begin
                pl_ready         = 1'b1;
                byte_D0          = pay[7:0];
                // On an odd final beat lane 1 carries the first CRC byte instead of payload
                byte_D1          = (nb == 2'd1) ? crc_nx[7:0] : pay[15:8];
                {vld_D1, vld_D0} = 2'b11;
                state_nx         = (nb == 2'd1) ? TAIL : (remain == 16'd2 ? CRC : PAY);
            end
            CRC: begin
                {byte_D1, byte_D0} = crc;
                {vld_D1, vld_D0}   = 2'b11;
                pkt_last           = 1'b1;
                state_nx           = IDLE;
            end
            TAIL: begin
                byte_D0  = crc[15:8];
                vld_D0   = 1'b1;
                pkt_last = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dsi_pkt_builder.sv
// tb_dsi_pkt_builder: randomized and directed checks of dsi_pkt_builder against a byte-stream model
module tb_dsi_pkt_builder;
    logic        CLKOP = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_long = 1'b0, pl_valid = 1'b0, err_clr = 1'b0;
    logic [1:0]  cmd_vc = '0;
    logic [5:0]  cmd_dt = '0;
    logic [15:0] cmd_wc = '0, pl_data = '0;
    logic        cmd_ready, pl_ready, vld_D0, vld_D1, pkt_last, busy, err_underrun;
    logic [7:0]  byte_D0, byte_D1;
    int          vectors = 0, miscompares = 0;
    logic [15:0] pd[$];
    logic        vm[$];

    // Syndrome of each header bit D0..D23 in the DSI Hamming code
    localparam logic [5:0] SYN [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                         6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                         6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    always #5 CLKOP = ~CLKOP;

    dsi_pkt_builder dut (
        .CLKOP(CLKOP), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_long(cmd_long), .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .byte_D0(byte_D0), .byte_D1(byte_D1), .vld_D0(vld_D0), .vld_D1(vld_D1),
        .pkt_last(pkt_last), .busy(busy), .err_underrun(err_underrun), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] ref_ecc(input logic [23:0] h);
        logic [5:0] e = 6'h00;
        for (int i = 0; i < 24; i++) if (h[i]) e ^= SYN[i];
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[k]) for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ b[k][i]) ? 16'h8408 : 16'h0000);
        return c;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_d0"}, byte_D0, 0);
        check({tag, "_d1"}, byte_D1, 0);
        check({tag, "_vld"}, {vld_D1, vld_D0}, 0);
        check({tag, "_last"}, pkt_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_pl_ready"}, pl_ready, 0);
    endtask

    task automatic send_pkt(input logic lng, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input logic clr_sim, input int abort_beat);
        logic [7:0]  bs[$];
        logic [7:0]  pay[$];
        logic [15:0] c, w;
        int          n, nbeats, pb, jj;
        logic        want_err = 1'b0;
        bs.push_back({vc, dt});
        bs.push_back(wc[7:0]);
        bs.push_back(wc[15:8]);
        bs.push_back(ref_ecc({wc, vc, dt}));
        pb = lng ? (int'(wc) + 1) / 2 : 0;
        for (int i = 0; i < (lng ? int'(wc) : 0); i++) begin
            w = pd[i / 2];
            pay.push_back(!vm[i / 2] ? 8'h00 : (i % 2 == 1) ? w[15:8] : w[7:0]);
            if (!vm[i / 2]) want_err = 1'b1;
        end
        if (lng) begin
            c = ref_crc(pay);
            foreach (pay[k]) bs.push_back(pay[k]);
            bs.push_back(c[7:0]);
            bs.push_back(c[15:8]);
        end
        n = bs.size();
        nbeats = (n + 1) / 2;
        @(negedge CLKOP);
        {cmd_long, cmd_vc, cmd_dt, cmd_wc, cmd_valid} = {lng, vc, dt, wc, 1'b1};
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge CLKOP);
        #1 cmd_valid = 1'b0;
        cmd_wc = 16'($urandom);
        for (int k = 0; k < nbeats; k++) begin
            jj = k - 2;
            if (jj >= 0 && jj < pb) begin
                pl_valid = vm[jj];
                pl_data  = vm[jj] ? pd[jj] : 16'($urandom);
                err_clr  = clr_sim && !vm[jj];
            end else begin
                pl_valid = 1'($urandom);
                pl_data  = 16'($urandom);
                err_clr  = 1'b0;
            end
            @(negedge CLKOP);
            if (k == abort_beat) begin
                reset_n = 1'b0;
                #1;
                check_quiet("abort");
                check("abort_err", err_underrun, 0);
                @(posedge CLKOP);
                #1 reset_n = 1'b1;
                {pl_valid, err_clr} = 2'b00;
                return;
            end
            check($sformatf("d0[%0d]", k), byte_D0, bs[2*k]);
            check($sformatf("v0[%0d]", k), vld_D0, 1);
            check($sformatf("d1[%0d]", k), byte_D1, (2*k+1 < n) ? bs[2*k+1] : 8'h00);
            check($sformatf("v1[%0d]", k), vld_D1, 2*k+1 < n);
            check($sformatf("last[%0d]", k), pkt_last, k == nbeats - 1);
            check($sformatf("pl_ready[%0d]", k), pl_ready, jj >= 0 && jj < pb);
            check($sformatf("busy[%0d]", k), busy, 1);
            check($sformatf("cmd_ready[%0d]", k), cmd_ready, 0);
            @(posedge CLKOP);
            #1;
        end
        {pl_valid, err_clr} = 2'b00;
        @(negedge CLKOP);
        check_quiet("post");
        check("err_sticky", err_underrun, want_err);
        if (want_err) begin
            err_clr = 1'b1;
            @(posedge CLKOP);
            #1 err_clr = 1'b0;
            @(negedge CLKOP);
            check("err_cleared", err_underrun, 0);
        end
    endtask

    initial begin
        #12;
        check_quiet("reset");
        check("reset_err", err_underrun, 0);
        @(negedge CLKOP);
        reset_n = 1'b1;
        send_pkt(1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, -1);
        send_pkt(1'b1, 2'd0, 6'h39, 16'h0000, 1'b0, -1);
        pd = '{16'h0201, 16'h0403};
        vm = '{1'b1, 1'b1};
        send_pkt(1'b1, 2'd0, 6'h39, 16'h0004, 1'b0, -1);
        pd = '{16'hA55A, 16'h3CC3};
        send_pkt(1'b1, 2'd1, 6'h39, 16'h0003, 1'b0, -1);
        pd = '{16'h1122, 16'h3344, 16'h5566};
        vm = '{1'b1, 1'b0, 1'b1};
        send_pkt(1'b1, 2'd0, 6'h39, 16'h0006, 1'b0, -1);
        send_pkt(1'b1, 2'd2, 6'h39, 16'h0006, 1'b1, -1);
        vm = '{1'b1, 1'b1, 1'b1};
        send_pkt(1'b1, 2'd3, 6'h39, 16'h0006, 1'b0, 3);
        send_pkt(1'b1, 2'd3, 6'h39, 16'h0006, 1'b0, -1);
        for (int t = 0; t < 40; t++) begin
            logic        lng = 1'($urandom);
            logic [15:0] wc  = lng ? 16'($urandom_range(0, 12)) : 16'($urandom);
            pd.delete();
            vm.delete();
            for (int j = 0; j < 6; j++) begin
                pd.push_back(16'($urandom));
                vm.push_back($urandom_range(0, 4) != 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge CLKOP);
            send_pkt(lng, 2'($urandom), 6'($urandom), wc, ($urandom_range(0, 3) == 0), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
